mdu_seq: RTL and testbench

//  Multi-cycle sequencer for the HI/LO multiply-divide resource (mult/multu/div/divu/mthi/mtlo).

---
 rtl/mdu_seq.sv | 154 +++++++++++++++
 tb/tb_mdu_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle sequencer for the HI/LO multiply-divide resource.
// Accepts mult/multu/div/divu/mthi/mtlo on start, holds busy for a fixed
// per-class latency, then commits the result to hi/lo.
// Optional feature macro: MDU_FLUSH_EN adds the flush input, which aborts an
// in-flight op.
//
// Handshake: start acts as "valid" and !busy acts as "ready". An op is
// accepted only on an edge where start==1 and busy==0. A start seen while busy
// is dropped, not queued. No result is committed for a dropped start.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   opa_q;
  logic [31:0]   opb_q;
  logic          sgn_q;   // 1 for mult/div, 0 for multu/divu
  logic          flush_hit;
  logic [63:0]   result;  // {hi, lo} to commit

`ifdef MDU_FLUSH_EN
  assign flush_hit = flush;
`else
  assign flush_hit = 1'b0;
`endif

  assign dbg_state = state;

  // Operand conditioning shared by the multiplier and the divider.
  logic        a_neg;
  logic        b_neg;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Datapath: one 64-bit multiplier on sign- or zero-extended operands gives
  // both the signed and the unsigned product. The divider works on magnitudes
  // and then fixes the signs. That path also covers 0x80000000 / -1 (the
  // quotient wraps to 0x80000000 and the remainder is 0).
  always_comb begin
    a_neg  = sgn_q & opa_q[31];
    b_neg  = sgn_q & opb_q[31];
    ext_a  = {{32{a_neg}}, opa_q};
    ext_b  = {{32{b_neg}}, opb_q};
    prod   = ext_a * ext_b;
    abs_a  = a_neg ? (32'd0 - opa_q) : opa_q;
    abs_b  = b_neg ? (32'd0 - opb_q) : opb_q;
    div_b  = (opb_q == 32'd0) ? 32'd1 : abs_b;  // keeps X out of the unused path
    q_mag  = abs_a / div_b;
    r_mag  = abs_a % div_b;
    result = prod;
    if (state == S_DIV) begin
      if (opb_q == 32'd0) begin
        result = {opa_q, 32'hFFFF_FFFF};
      end else begin
        result[31:0]  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        result[63:32] = a_neg ? (32'd0 - r_mag) : r_mag;
      end
    end
  end

  // Sequencer: issue from IDLE, count down the latency, commit or abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      opa_q <= 32'd0;
      opb_q <= 32'd0;
      sgn_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd1, 3'd2: begin
                state <= S_MUL;
                busy  <= 1'b1;
                count <= MUL_LOAD;
                opa_q <= rs_val;
                opb_q <= rt_val;
                sgn_q <= op[0];
              end
              3'd3, 3'd4: begin
                state <= S_DIV;
                busy  <= 1'b1;
                count <= DIV_LOAD;
                opa_q <= rs_val;
                opb_q <= rt_val;
                sgn_q <= op[0];
              end
              3'd5:    hi <= rs_val;
              3'd6:    lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (flush_hit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else if (count == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            hi    <= result[63:32];
            lo    <= result[31:0];
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq. Expected {hi,lo} results come
// from an independent 64-bit arithmetic model and are queued at issue. They are
// popped and compared when busy falls.
module tb_mdu_seq;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
`ifdef MDU_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mdu_seq #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
`ifdef MDU_FLUSH_EN
    .flush     (flush),
`endif
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] model_res(input logic [2:0] mop, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (mop)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (mop == 3'd3) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Driver: one-cycle start pulse, launched at negedge, sampled #1 after posedge.
  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Wait for busy to fall. The count of busy cycles seen so far is passed in.
  // Then check the latency and pop the expected result.
  task automatic wait_done(input string tag, input int n, input int seen);
    int cyc;
    logic [63:0] e;
    cyc = seen;
    while (busy === 1'b1 && cyc <= 200) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) cyc++;
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'(n));
    if (exp_q.size() == 0) begin
      check_val({tag, "_sbempty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      model_hi = e[63:32];
      model_lo = e[31:0];
      check_val({tag, "_hilo"}, {hi, lo}, e);
    end
  endtask

  // Run one op from idle and check it completely.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    pulse(o, a, b);
    case (o)
      3'd1, 3'd2, 3'd3, 3'd4: begin
        exp_q.push_back(model_res(o, a, b));
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        check_val({tag, "_state"}, 64'(dbg_state), (o <= 3'd2) ? 64'd1 : 64'd2);
        check_val({tag, "_hold"}, {hi, lo}, {model_hi, model_lo});
        wait_done(tag, (o <= 3'd2) ? MULT_CYCLES : DIV_CYCLES, 1);
      end
      default: begin
        if (o == 3'd5) model_hi = a;
        if (o == 3'd6) model_lo = a;
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_hilo"}, {hi, lo}, {model_hi, model_lo});
      end
    endcase
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  initial begin
    // Reset
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_hilo", {hi, lo}, 64'd0);
    check_val("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_op("mult_m2x3", 3'd1, 32'hFFFF_FFFE, 32'd3);
    check_val("mult_m2x3_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7);
    check_val("divu_100_7_lit", {hi, lo}, {32'd2, 32'd14});
    run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
    check_val("div_m7_2_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_by0", 3'd3, 32'd5, 32'd0);
    check_val("div_by0_lit", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("div_ovf_lit", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op("divu_by0", 3'd4, 32'hABCD_0001, 32'd0);
    run_op("multu_big", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mthi", 3'd5, 32'h0000_1234, 32'd0);
    check_val("mthi_lit", 64'(hi), 64'h1234);
    run_op("mtlo", 3'd6, 32'h5555_AAAA, 32'd0);
    run_op("nop0", 3'd0, 32'h1111_1111, 32'd1);
    run_op("nop7", 3'd7, 32'h2222_2222, 32'd2);

    // mtlo arriving during a mult busy window is dropped
    pulse(3'd1, 32'd7, 32'd9);
    exp_q.push_back(model_res(3'd1, 32'd7, 32'd9));
    pulse(3'd6, 32'h0000_DEAD, 32'd0);
    check_val("ign_busy", 64'(busy), 64'd1);
    wait_done("ign_mtlo", MULT_CYCLES, 2);
    check_val("ign_lo", 64'(lo), 64'd63);

    // Reset in cycle 3 of a mult: everything clears and nothing commits later
    pulse(3'd1, 32'd11, 32'd13);
    exp_q.push_back(model_res(3'd1, 32'd11, 32'd13));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_hilo", {hi, lo}, 64'd0);
    void'(exp_q.pop_back());
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_val("midrst_late_busy", 64'(busy), 64'd0);
    check_val("midrst_late_hilo", {hi, lo}, 64'd0);

`ifdef MDU_FLUSH_EN
    // Flush on cycle 5 of a multu: aborts with hi/lo unchanged
    run_op("pre_flush", 3'd2, 32'd40, 32'd50);
    pulse(3'd2, 32'd2, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_val("flush_busy", 64'(busy), 64'd0);
    check_val("flush_hilo", {hi, lo}, {model_hi, model_lo});
    // Next cycle: flush while idle must not block a same-cycle start
    @(negedge clk);
    flush  = 1'b1;
    start  = 1'b1;
    op     = 3'd1;
    rs_val = 32'd4;
    rt_val = 32'd5;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    exp_q.push_back(model_res(3'd1, 32'd4, 32'd5));
    check_val("flush_idle_start", 64'(busy), 64'd1);
    wait_done("post_flush", MULT_CYCLES, 1);
`endif

    // Random ops, back-to-back from the first idle cycle
    for (int i = 0; i < 16; i++) begin
      r_op = 3'($urandom_range(1, 6));
      r_a  = $urandom();
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 2) == 0) r_b = 32'($urandom_range(1, 20));
      run_op("rand", r_op, r_a, r_b);
    end

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
